multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller.sv | 164 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath. It steps each instruction through
// fetch/decode/execute/memory/writeback and derives every strobe and select from the current state.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [1:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic [2:0] alucontrol,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BEQ      = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic [3:0] state_q, state_d;
    logic [1:0] aluop;
    logic       branch;
    logic       pcupdate;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTER;
                    OP_ITYPE:     state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            JAL:      state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        resultsrc = 2'b00;
        adrsrc    = 1'b0;
        aluop     = 2'b00;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        branch    = 1'b0;
        pcupdate  = 1'b0;
        case (state_q)
            FETCH: begin
                irwrite   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                pcupdate  = 1'b1;
            end
            DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            MEMREAD:  adrsrc = 1'b1;
            MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
            end
            MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTER: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
            end
            EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
            end
            ALUWB:    regwrite = 1'b1;
            BEQ: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
            end
            JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
            end
            default: ;
        endcase
    end

    // Only R-type (op[5] set) with funct7b5 subtracts; addi shares funct3=000 but must add.
    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            2'b01: alucontrol = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol = 3'b101;
                    3'b110:  alucontrol = 3'b011;
                    3'b111:  alucontrol = 3'b010;
                    default: alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    assign pcwrite = pcupdate | (branch & zero);
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level reference model (state sequence per
// opcode plus per-state output table) compared every cycle, with directed and random instructions.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
    logic       adrsrc;
    logic [2:0] alucontrol;
    logic       irwrite, pcwrite, regwrite, memwrite;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;
    int pos;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc),
        .adrsrc(adrsrc), .alucontrol(alucontrol), .irwrite(irwrite), .pcwrite(pcwrite),
        .regwrite(regwrite), .memwrite(memwrite), .state(state)
    );

    always #5 clk = ~clk;

    // Cycles per instruction, FETCH through last state.
    function automatic int seq_len(input logic [6:0] o);
        case (o)
            LW:             return 5;
            SW, RT, IT, JL: return 4;
            BQ:             return 3;
            default:        return 2;
        endcase
    endfunction

    // State visited at position p (0 = fetch) of the instruction with opcode o.
    function automatic logic [3:0] seq_at(input logic [6:0] o, input int p);
        if (p == 0) return 4'd0;
        if (p == 1) return 4'd1;
        case (o)
            LW:      return (p == 2) ? 4'd2 : (p == 3) ? 4'd3 : 4'd4;
            SW:      return (p == 2) ? 4'd2 : 4'd5;
            RT:      return (p == 2) ? 4'd6 : 4'd8;
            IT:      return (p == 2) ? 4'd7 : 4'd8;
            JL:      return (p == 2) ? 4'd10 : 4'd8;
            BQ:      return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

    // {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol, irwrite, pcwrite, regwrite, memwrite}
    function automatic logic [15:0] exp_out(input logic [3:0] st, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7, input logic z);
        logic [1:0] imm, a, b, rs, aop;
        logic       adr, irw, pcu, br, rw, mw;
        logic [2:0] ac;
        imm = 2'd0; a = 2'd0; b = 2'd0; rs = 2'd0; aop = 2'd0;
        adr = 0; irw = 0; pcu = 0; br = 0; rw = 0; mw = 0; ac = 3'd0;
        case (o)
            SW:      imm = 2'd1;
            BQ:      imm = 2'd2;
            JL:      imm = 2'd3;
            default: imm = 2'd0;
        endcase
        case (st)
            4'd0:  begin adr = 0; irw = 1; a = 0; b = 2; rs = 2; pcu = 1; end
            4'd1:  begin a = 1; b = 1; end
            4'd2:  begin a = 2; b = 1; end
            4'd3:  begin rs = 0; adr = 1; end
            4'd4:  begin rs = 1; rw = 1; end
            4'd5:  begin rs = 0; adr = 1; mw = 1; end
            4'd6:  begin a = 2; b = 0; aop = 2; end
            4'd7:  begin a = 2; b = 1; aop = 2; end
            4'd8:  begin rs = 0; rw = 1; end
            4'd9:  begin a = 2; b = 0; aop = 1; br = 1; end
            4'd10: begin a = 1; b = 2; pcu = 1; end
            default: ;
        endcase
        if (aop == 2'd1) ac = 3'b001;
        else if (aop == 2'd2) begin
            if (f3 == 3'b000)      ac = (o[5] && f7) ? 3'b001 : 3'b000;
            else if (f3 == 3'b010) ac = 3'b101;
            else if (f3 == 3'b110) ac = 3'b011;
            else if (f3 == 3'b111) ac = 3'b010;
        end
        return {imm, a, b, rs, adr, ac, irw, pcu | (br & z), rw, mw};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) pos <= 0;
        else       pos <= (pos + 1 >= seq_len(op)) ? 0 : pos + 1;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
    endtask

    initial begin
        logic [3:0]  es;
        logic [15:0] eo;
        reset = 1'b1;
        drive(LW, 3'd0, 1'b0, 1'b0);
        fork
            forever begin
                @(negedge clk);
                #2;
                es = seq_at(op, pos);
                eo = exp_out(es, op, funct3, funct7b5, zero);
                chk("model_state", {28'd0, state}, {28'd0, es});
                chk("model_outs",
                    {16'd0, immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
                     irwrite, pcwrite, regwrite, memwrite}, {16'd0, eo});
            end
            begin
                repeat (3) @(negedge clk);
                #1;
                chk("rst_state", {28'd0, state}, 32'd0);
                chk("rst_irwrite", {31'd0, irwrite}, 32'd1);
                chk("rst_pcwrite", {31'd0, pcwrite}, 32'd1);
                chk("rst_alusrcb", {30'd0, alusrcb}, 32'd2);
                chk("rst_resultsrc", {30'd0, resultsrc}, 32'd2);
                chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
                @(negedge clk);
                reset = 1'b0;

                // lw
                drive(LW, 3'b010, 1'b0, 1'b0);
                #2 chk("lw_fetch", {28'd0, state}, 32'd0);
                @(negedge clk); #2 chk("lw_decode", {28'd0, state}, 32'd1);
                @(negedge clk); #2 chk("lw_memadr", {28'd0, state}, 32'd2);
                chk("lw_immsrc", {30'd0, immsrc}, 32'd0);
                chk("lw_aluctl", {29'd0, alucontrol}, 32'd0);
                @(negedge clk); #2 chk("lw_memread", {28'd0, state}, 32'd3);
                chk("lw_adrsrc", {31'd0, adrsrc}, 32'd1);
                @(negedge clk); #2 chk("lw_memwb", {28'd0, state}, 32'd4);
                chk("lw_regwrite", {31'd0, regwrite}, 32'd1);
                chk("lw_resultsrc", {30'd0, resultsrc}, 32'd1);
                @(negedge clk);

                // sw
                drive(SW, 3'b010, 1'b0, 1'b0);
                #2 chk("sw_immsrc", {30'd0, immsrc}, 32'd1);
                chk("sw_memwrite_fetch", {31'd0, memwrite}, 32'd0);
                repeat (3) @(negedge clk);
                #2 chk("sw_memwrite_st", {28'd0, state}, 32'd5);
                chk("sw_memwrite", {31'd0, memwrite}, 32'd1);
                chk("sw_adrsrc", {31'd0, adrsrc}, 32'd1);
                @(negedge clk);

                // R-type sub and I-type with the same fields
                drive(RT, 3'b000, 1'b1, 1'b0);
                repeat (2) @(negedge clk);
                #2 chk("r_sub_state", {28'd0, state}, 32'd6);
                chk("r_sub_aluctl", {29'd0, alucontrol}, 32'd1);
                repeat (2) @(negedge clk);
                drive(IT, 3'b000, 1'b1, 1'b0);
                repeat (2) @(negedge clk);
                #2 chk("i_add_state", {28'd0, state}, 32'd7);
                chk("i_add_aluctl", {29'd0, alucontrol}, 32'd0);
                repeat (2) @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    logic [2:0] f3;
                    logic [2:0] ea;
                    f3 = (k == 0) ? 3'b110 : (k == 1) ? 3'b111 : 3'b010;
                    ea = (k == 0) ? 3'b011 : (k == 1) ? 3'b010 : 3'b101;
                    drive(RT, f3, 1'b0, 1'b0);
                    repeat (2) @(negedge clk);
                    #2 chk("r_funct3_aluctl", {29'd0, alucontrol}, {29'd0, ea});
                    repeat (2) @(negedge clk);
                end

                // beq taken and not taken
                drive(BQ, 3'b000, 1'b0, 1'b1);
                repeat (2) @(negedge clk);
                #2 chk("beq_t_state", {28'd0, state}, 32'd9);
                chk("beq_t_pcwrite", {31'd0, pcwrite}, 32'd1);
                chk("beq_t_aluctl", {29'd0, alucontrol}, 32'd1);
                @(negedge clk);
                drive(BQ, 3'b000, 1'b0, 1'b0);
                repeat (2) @(negedge clk);
                #2 chk("beq_nt_pcwrite", {31'd0, pcwrite}, 32'd0);
                @(negedge clk);

                // jal
                drive(JL, 3'b000, 1'b0, 1'b0);
                #2 chk("jal_immsrc", {30'd0, immsrc}, 32'd3);
                repeat (2) @(negedge clk);
                #2 chk("jal_state", {28'd0, state}, 32'd10);
                chk("jal_pcwrite", {31'd0, pcwrite}, 32'd1);
                @(negedge clk); #2 chk("jal_aluwb", {28'd0, state}, 32'd8);
                chk("jal_regwrite", {31'd0, regwrite}, 32'd1);
                @(negedge clk);

                // illegal opcode
                drive(7'b1111111, 3'b000, 1'b0, 1'b0);
                @(negedge clk);
                #2 chk("ill_decode", {28'd0, state}, 32'd1);
                chk("ill_strobes", {28'd0, irwrite, pcwrite, regwrite, memwrite}, 32'd0);
                @(negedge clk);
                #2 chk("ill_back", {28'd0, state}, 32'd0);
                @(negedge clk);
                drive(7'b0000000, 3'b000, 1'b0, 1'b0);
                @(negedge clk);

                // async reset mid-MEMREAD, then a full lw
                drive(LW, 3'b010, 1'b0, 1'b0);
                repeat (3) @(negedge clk);
                #3 reset = 1'b1;
                #1;
                chk("mid_rst_state", {28'd0, state}, 32'd0);
                chk("mid_rst_irwrite", {31'd0, irwrite}, 32'd1);
                chk("mid_rst_pcwrite", {31'd0, pcwrite}, 32'd1);
                chk("mid_rst_regwrite", {31'd0, regwrite}, 32'd0);
                chk("mid_rst_memwrite", {31'd0, memwrite}, 32'd0);
                @(negedge clk);
                reset = 1'b0;
                repeat (5) @(negedge clk);

                // random instruction stream
                repeat (250) begin
                    int r;
                    logic [6:0] o;
                    r = $urandom_range(0, 7);
                    case (r)
                        0: o = LW;
                        1: o = SW;
                        2: o = RT;
                        3: o = IT;
                        4: o = BQ;
                        5: o = JL;
                        default: o = 7'($urandom);
                    endcase
                    drive(o, 3'($urandom), 1'($urandom), 1'b0);
                    for (int i = 0; i < seq_len(o); i++) begin
                        zero = 1'($urandom);
                        @(negedge clk);
                    end
                end
                #3;
            end
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
